// File: rtl/spi_slave_ctrl_if.sv
// Bus between the SPI slave front end and its neighbours: the SPI pins plus
// the rx/tx handshake toward the RAM block.
interface spi_slave_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  SS_n;
  logic                  MOSI;
  logic                  MISO;
  logic [DATA_WIDTH+1:0] rx_data;
  logic                  rx_valid;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;

  modport slave (
    input  SS_n, MOSI, tx_data, tx_valid,
    output MISO, rx_data, rx_valid
  );

  modport master (
    output SS_n, MOSI, tx_data, tx_valid,
    input  MISO, rx_data, rx_valid
  );
endinterface

// File: rtl/spi_slave_ctrl.sv
// SPI slave front end: deserialises command+data frames for the RAM and
// serialises the RAM's read byte back onto MISO, one bit per clk edge.
module spi_slave_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  spi_slave_ctrl_if.slave  bus
);
  localparam int FRAME_W = DATA_WIDTH + 2;
  localparam int CNT_W   = $clog2(FRAME_W);
  localparam int TX_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);

  typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;

  state_t                  state_reg, state_next;
  logic [CNT_W-1:0]        bit_cnt_reg, bit_cnt_next;
  logic [FRAME_W-2:0]      rx_shift_reg, rx_shift_next;
  logic [FRAME_W-1:0]      rx_data_reg, rx_data_next;
  logic                    rx_valid_reg, rx_valid_next;
  logic                    frame_done_reg, frame_done_next;
  logic                    rd_addr_flag_reg, rd_addr_flag_next;
  logic [DATA_WIDTH-1:0]   tx_shift_reg, tx_shift_next;
  logic [TX_W-1:0]         tx_cnt_reg, tx_cnt_next;
  logic                    tx_busy_reg, tx_busy_next;
  logic                    tx_done_reg, tx_done_next;
  logic                    miso_reg, miso_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= IDLE;
      bit_cnt_reg      <= '0;
      rx_shift_reg     <= '0;
      rx_data_reg      <= '0;
      rx_valid_reg     <= 1'b0;
      frame_done_reg   <= 1'b0;
      rd_addr_flag_reg <= 1'b0;
      tx_shift_reg     <= '0;
      tx_cnt_reg       <= '0;
      tx_busy_reg      <= 1'b0;
      tx_done_reg      <= 1'b0;
      miso_reg         <= 1'b0;
    end else begin
      state_reg        <= state_next;
      bit_cnt_reg      <= bit_cnt_next;
      rx_shift_reg     <= rx_shift_next;
      rx_data_reg      <= rx_data_next;
      rx_valid_reg     <= rx_valid_next;
      frame_done_reg   <= frame_done_next;
      rd_addr_flag_reg <= rd_addr_flag_next;
      tx_shift_reg     <= tx_shift_next;
      tx_cnt_reg       <= tx_cnt_next;
      tx_busy_reg      <= tx_busy_next;
      tx_done_reg      <= tx_done_next;
      miso_reg         <= miso_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    bit_cnt_next      = bit_cnt_reg;
    rx_shift_next     = rx_shift_reg;
    rx_data_next      = rx_data_reg;
    rx_valid_next     = 1'b0;
    frame_done_next   = frame_done_reg;
    rd_addr_flag_next = rd_addr_flag_reg;
    tx_shift_next     = tx_shift_reg;
    tx_cnt_next       = tx_cnt_reg;
    tx_busy_next      = tx_busy_reg;
    tx_done_next      = tx_done_reg;
    miso_next         = miso_reg;

    case (state_reg)
      IDLE: begin
        if (!bus.SS_n) state_next = CHK_CMD;
      end

      CHK_CMD: begin
        if (bus.SS_n) begin
          state_next = IDLE;
        end else begin
          rx_shift_next = {rx_shift_reg[FRAME_W-3:0], bus.MOSI};
          bit_cnt_next  = CNT_W'(1);
          if (!bus.MOSI)             state_next = WRITE;
          else if (rd_addr_flag_reg) state_next = READ_DATA;
          else                       state_next = READ_ADD;
        end
      end

      default: begin
        if (bus.SS_n) begin
          // Abort: drop the partial frame and any readback; flag is kept.
          state_next      = IDLE;
          bit_cnt_next    = '0;
          rx_shift_next   = '0;
          frame_done_next = 1'b0;
          tx_shift_next   = '0;
          tx_cnt_next     = '0;
          tx_busy_next    = 1'b0;
          tx_done_next    = 1'b0;
          miso_next       = 1'b0;
        end else if (!frame_done_reg) begin
          rx_shift_next = {rx_shift_reg[FRAME_W-3:0], bus.MOSI};
          if (bit_cnt_reg == LAST_BIT) begin
            rx_data_next    = {rx_shift_reg, bus.MOSI};
            rx_valid_next   = 1'b1;
            frame_done_next = 1'b1;
            bit_cnt_next    = '0;
            if (state_reg == READ_ADD)  rd_addr_flag_next = 1'b1;
            if (state_reg == READ_DATA) rd_addr_flag_next = 1'b0;
          end else begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
          end
        end else if (state_reg == READ_DATA && !tx_done_reg) begin
          if (tx_busy_reg) begin
            // tx_cnt counts bits still queued behind the one on MISO.
            if (tx_cnt_reg != '0) begin
              miso_next     = tx_shift_reg[DATA_WIDTH-1];
              tx_shift_next = {tx_shift_reg[DATA_WIDTH-2:0], 1'b0};
              tx_cnt_next   = tx_cnt_reg - 1'b1;
            end else begin
              miso_next    = 1'b0;
              tx_busy_next = 1'b0;
              tx_done_next = 1'b1;
            end
          end else if (bus.tx_valid) begin
            miso_next     = bus.tx_data[DATA_WIDTH-1];
            tx_shift_next = {bus.tx_data[DATA_WIDTH-2:0], 1'b0};
            tx_cnt_next   = TX_W'(DATA_WIDTH - 1);
            tx_busy_next  = 1'b1;
          end
        end
      end
    endcase
  end

  assign bus.MISO     = miso_reg;
  assign bus.rx_data  = rx_data_reg;
  assign bus.rx_valid = rx_valid_reg;
endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Directed + randomised bench for spi_slave_ctrl against a frame-level model
// (expected frame, read path chosen from a single read-address flag).
module tb_spi_slave_ctrl;
  logic clk;
  logic rst;

  spi_slave_ctrl_if #(.DATA_WIDTH(8)) bus ();

  spi_slave_ctrl #(.DATA_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Model state: read-address flag, last completed frame, path of current frame.
  logic       m_flag;
  logic [9:0] m_last;
  bit         m_rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [9:0] f, input int nbits, output bit done);
    bus.SS_n = 1'b0;
    step();
    for (int i = 0; i < nbits && i < 10; i++) begin
      bus.MOSI = f[9-i];
      step();
      check("miso_in_frame", 32'(bus.MISO), 32'd0);
      if (i < 9) check("rx_valid_early", 32'(bus.rx_valid), 32'd0);
    end
    if (nbits < 10) begin
      bus.SS_n = 1'b1;
      bus.MOSI = 1'($urandom_range(0, 1));
      step();
      check("abort_rx_valid", 32'(bus.rx_valid), 32'd0);
      check("abort_rx_data", 32'(bus.rx_data), 32'(m_last));
      check("abort_miso", 32'(bus.MISO), 32'd0);
      done = 1'b0;
      return;
    end
    check("rx_valid_pulse", 32'(bus.rx_valid), 32'd1);
    check("rx_data", 32'(bus.rx_data), 32'(f));
    m_rd   = f[9] && m_flag;
    if (f[9]) m_flag = ~m_flag;
    m_last = f;
    bus.MOSI = 1'($urandom_range(0, 1));
    step();
    check("rx_valid_single", 32'(bus.rx_valid), 32'd0);
    check("rx_data_hold", 32'(bus.rx_data), 32'(f));
    done = 1'b1;
  endtask

  task automatic readback(input logic [7:0] b, input int rst_k);
    int wait_n;
    wait_n = int'($urandom_range(0, 3));
    repeat (wait_n) begin
      step();
      check("miso_wait", 32'(bus.MISO), 32'd0);
    end
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    step();
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'($urandom_range(0, 255));
    for (int k = 7; k >= 0; k--) begin
      check("miso_bit", 32'(bus.MISO), 32'(b[k]));
      if (k == rst_k) begin
        #3 rst = 1'b1;
        #1;
        check("rst_miso", 32'(bus.MISO), 32'd0);
        check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
        check("rst_rx_data", 32'(bus.rx_data), 32'd0);
        m_flag = 1'b0;
        m_last = 10'd0;
        @(negedge clk);
        bus.SS_n     = 1'b1;
        bus.tx_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        step();
        check("post_rst_miso", 32'(bus.MISO), 32'd0);
        return;
      end
      if (k == 4) begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = ~b;
      end
      step();
      bus.tx_valid = 1'b0;
    end
    check("miso_tail", 32'(bus.MISO), 32'd0);
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'hFF;
    step();
    bus.tx_valid = 1'b0;
    check("miso_after", 32'(bus.MISO), 32'd0);
  endtask

  task automatic post_frame(input logic [7:0] b);
    if (m_rd) begin
      readback(b, -1);
    end else begin
      bus.tx_data  = b | 8'h80;
      bus.tx_valid = 1'b1;
      step();
      bus.tx_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
        check("miso_quiet", 32'(bus.MISO), 32'd0);
        step();
      end
    end
    bus.SS_n = 1'b1;
    step();
    check("idle_miso", 32'(bus.MISO), 32'd0);
  endtask

  initial begin
    bit done;
    rst = 1'b1;
    bus.SS_n = 1'b1;
    bus.MOSI = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data = 8'd0;
    m_flag = 1'b0;
    m_last = 10'd0;
    m_rd = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("reset_miso", 32'(bus.MISO), 32'd0);
    check("reset_rx_valid", 32'(bus.rx_valid), 32'd0);
    check("reset_rx_data", 32'(bus.rx_data), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();

    send_frame(10'h0A5, 10, done);
    post_frame(8'h5A);
    send_frame(10'h1FF, 10, done);
    post_frame(8'hFF);
    send_frame(10'h233, 10, done);
    post_frame(8'h81);
    send_frame(10'h300, 10, done);
    post_frame(8'hC3);
    send_frame(10'h355, 10, done);
    post_frame(8'hAA);
    send_frame(10'h2F0, 5, done);
    send_frame(10'h001, 10, done);
    post_frame(8'h3C);

    for (int n = 0; n < 16; n++) begin
      logic [9:0] f;
      int nb;
      f  = 10'($urandom_range(0, 1023));
      nb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 9)) : 10;
      send_frame(f, nb, done);
      if (done) post_frame(8'($urandom_range(0, 255)));
    end

    if (!m_flag) begin
      send_frame(10'h2A0 | 10'($urandom_range(0, 31)), 10, done);
      post_frame(8'h11);
    end
    send_frame(10'h300 | 10'($urandom_range(0, 255)), 10, done);
    readback(8'hA5, 3);
    bus.SS_n = 1'b1;
    step();
    send_frame(10'h3C0, 10, done);
    post_frame(8'hF0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end
endmodule
